// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared state encodings and defaults for the Pong path arbiter.
package mux_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_HOLD_W   = 5;
endpackage

// File: rtl/mux_arbiter_sat_counter.sv
// sat_counter: saturating up-counter with sync clear and a terminal flag at LIMIT-1.
module sat_counter #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_term
);
    logic [WIDTH-1:0] r_cnt;
    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == WIDTH'(LIMIT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && !o_term)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter driving the shared Mux select,
// with a bounded hold time while the other side is waiting.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = DEF_HOLD_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_a,
    input  logic req_b,
    input  logic done_a,
    input  logic done_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic busy,
    output logic preempt
);
    state_t            r_state, w_next;
    logic              r_last_a;
    logic              w_preempt, w_term, w_enter;
    logic [HOLD_W-1:0] w_unused_cnt;

    // Voluntary release is checked before the hold limit so a coincident
    // done never raises preempt.
    always_comb begin
        w_next    = r_state;
        w_preempt = 1'b0;
        case (r_state)
            ST_IDLE:
                w_next = (req_a && req_b) ? (r_last_a ? ST_OWN_B : ST_OWN_A) :
                         req_a ? ST_OWN_A : req_b ? ST_OWN_B : ST_IDLE;
            ST_OWN_A:
                if (done_a || !req_a)
                    w_next = req_b ? ST_OWN_B : ST_IDLE;
                else if (w_term && req_b) begin
                    w_next    = ST_OWN_B;
                    w_preempt = 1'b1;
                end
            ST_OWN_B:
                if (done_b || !req_b)
                    w_next = req_a ? ST_OWN_A : ST_IDLE;
                else if (w_term && req_a) begin
                    w_next    = ST_OWN_A;
                    w_preempt = 1'b1;
                end
            default:
                w_next = ST_IDLE;
        endcase
    end

    assign w_enter = (w_next != ST_IDLE) && (w_next != r_state);

    sat_counter #(
        .WIDTH(HOLD_W),
        .LIMIT(MAX_HOLD)
    ) u_hold (
        .clk   (clk),
        .rst_n (reset_n),
        .i_clr (w_enter),
        .i_en  (r_state != ST_IDLE),
        .o_cnt (w_unused_cnt),
        .o_term(w_term)
    );

    // sel only moves on a grant entry so the Mux output stays put through IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_last_a <= 1'b0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            sel      <= 1'b1;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            r_state <= w_next;
            gnt_a   <= (w_next == ST_OWN_A);
            gnt_b   <= (w_next == ST_OWN_B);
            busy    <= (w_next != ST_IDLE);
            preempt <= w_preempt;
            if (w_enter) begin
                r_last_a <= (w_next == ST_OWN_A);
                sel      <= (w_next == ST_OWN_A);
            end
        end
    end
endmodule
